// File: rtl/ravenoc_pkg.sv
// rtl/ravenoc_pkg.sv - shared flit types, arbiter state and default sizes for the router output port
package ravenoc_pkg;

    localparam int FLIT_W  = 34;
    localparam int N_PORTS = 5;
    localparam int CNT_W   = 16;

    typedef enum logic [1:0] {
        HEAD      = 2'b00,
        BODY      = 2'b01,
        TAIL      = 2'b10,
        HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    function automatic logic is_head(input logic [1:0] t);
        return (t == HEAD) || (t == HEAD_TAIL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter: first requester at or after ptr wins
module rr_arbiter #(
    parameter int N     = 5,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    always_comb begin
        logic             found;
        logic [PTR_W-1:0] idx;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PTR_W'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_arbiter_wh.sv
// rtl/output_arbiter_wh.sv - wormhole output-port arbiter with registered output stage
// Optional per-port packet counters enabled by defining OUT_ARB_STATS_EN.
module output_arbiter_wh #(
    parameter int FLIT_W  = ravenoc_pkg::FLIT_W,
    parameter int N_PORTS = ravenoc_pkg::N_PORTS,
    parameter int CNT_W   = ravenoc_pkg::CNT_W
) (
    input  logic                       clk,
    input  logic                       arst,
    input  logic [N_PORTS-1:0]         req_i,
    input  logic [N_PORTS*FLIT_W-1:0]  flit_i,
    input  logic [N_PORTS-1:0]         valid_i,
    output logic [N_PORTS-1:0]         ready_o,
    output logic [FLIT_W-1:0]          flit_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [N_PORTS*CNT_W-1:0]   pkt_cnt_o
);
    import ravenoc_pkg::*;

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    arb_state_t          state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    lock_q, lock_d;
    logic [PTR_W-1:0]    win_idx;
    logic [N_PORTS-1:0]  eligible, rr_grant, grant;
    logic [FLIT_W-1:0]   sel_flit;
    logic [1:0]          sel_type;
    logic                load_ok, xfer_in;

    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] x);
        return (x == PTR_W'(N_PORTS - 1)) ? '0 : x + 1'b1;
    endfunction

    always_comb begin
        eligible = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            eligible[p] = req_i[p] & valid_i[p] & is_head(flit_i[p*FLIT_W + FLIT_W - 2 +: 2]);
        end
    end

    rr_arbiter #(.N(N_PORTS), .PTR_W(PTR_W)) u_rr (
        .req   (eligible),
        .ptr   (ptr_q),
        .grant (rr_grant)
    );

    // While a packet is in flight only its source may move; nobody else is even considered.
    always_comb begin
        grant = '0;
        if (state_q == ARB_LOCKED) begin
            grant[lock_q] = 1'b1;
        end else begin
            grant = rr_grant;
        end
    end

    assign load_ok = !valid_o || ready_i;
    assign ready_o = arst ? '0 : (grant & {N_PORTS{load_ok}});
    assign xfer_in = |(valid_i & ready_o);

    always_comb begin
        win_idx  = '0;
        sel_flit = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (grant[p]) begin
                win_idx  = PTR_W'(p);
                sel_flit = flit_i[p*FLIT_W +: FLIT_W];
            end
        end
    end

    assign sel_type = sel_flit[FLIT_W-1 -: 2];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lock_d  = lock_q;
        case (state_q)
            ARB_IDLE: begin
                if (xfer_in) begin
                    if (sel_type == HEAD) begin
                        state_d = ARB_LOCKED;
                        lock_d  = win_idx;
                    end else begin
                        ptr_d = next_port(win_idx);
                    end
                end
            end
            ARB_LOCKED: begin
                if (xfer_in && (sel_type == TAIL)) begin
                    state_d = ARB_IDLE;
                    ptr_d   = next_port(lock_q);
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
            valid_o <= 1'b0;
            flit_o  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lock_q  <= lock_d;
            if (xfer_in) begin
                flit_o  <= sel_flit;
                valid_o <= 1'b1;
            end else if (ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

    // A new head from the locked port means the upstream lost a tail; it is forwarded regardless.
    assert property (@(posedge clk) disable iff (arst)
        !((state_q == ARB_LOCKED) && xfer_in && is_head(sel_type)));

`ifdef OUT_ARB_STATS_EN
    logic [CNT_W-1:0] cnt_q [N_PORTS];

    always_ff @(posedge clk) begin
        if (arst) begin
            for (int p = 0; p < N_PORTS; p++) begin
                cnt_q[p] <= '0;
            end
        end else if (xfer_in && sel_type[1]) begin
            if (cnt_q[win_idx] != '1) begin
                cnt_q[win_idx] <= cnt_q[win_idx] + CNT_W'(1);
            end
        end
    end

    for (genvar g = 0; g < N_PORTS; g++) begin : g_cnt
        assign pkt_cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
    end
`else
    assign pkt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_output_arbiter_wh.sv
// tb/tb_output_arbiter_wh.sv - randomized and directed checks of output_arbiter_wh against a packet-level model
module tb_output_arbiter_wh;

    localparam int NP = 5;
    localparam int FW = 34;
    localparam int CW = 16;
`ifdef OUT_ARB_STATS_EN
    localparam int EXP_P2 = 3;
`else
    localparam int EXP_P2 = 0;
`endif

    logic              clk = 1'b0;
    logic              arst;
    logic [NP-1:0]     req_i, valid_i, ready_o;
    logic [NP*FW-1:0]  flit_i;
    logic [FW-1:0]     flit_o;
    logic              valid_o, ready_i;
    logic [NP*CW-1:0]  pkt_cnt_o;

    always #5 clk = ~clk;

    output_arbiter_wh dut (
        .clk       (clk),
        .arst      (arst),
        .req_i     (req_i),
        .flit_i    (flit_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .flit_o    (flit_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .pkt_cnt_o (pkt_cnt_o)
    );

    int checks = 0;
    int failures = 0;

    // upstream packet sources
    int act[NP], len[NP], k[NP], seq[NP];
    bit vld[NP], rq[NP];

    // packet-level reference
    bit            m_locked, m_valid;
    int            m_lock, m_ptr, win;
    logic [FW-1:0] m_flit;
    int            m_cnt[NP];
    logic [NP-1:0] exp_ready, seen_ready;

    task automatic chk(input string nm, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, actual, expected, $time);
        end
    endtask

    function automatic logic [1:0] ftype(input int p);
        if (len[p] == 1) return 2'b11;
        if (k[p] == 0) return 2'b00;
        if (k[p] == len[p] - 1) return 2'b10;
        return 2'b01;
    endfunction

    function automatic logic [FW-1:0] mkflit(input int p);
        return {ftype(p), 8'(p), 16'(seq[p]), 8'(k[p])};
    endfunction

    task automatic start(input int p, input int l);
        act[p] = 1; len[p] = l; k[p] = 0; seq[p]++; vld[p] = 1; rq[p] = 1;
    endtask

    task automatic clear_upstream();
        for (int p = 0; p < NP; p++) begin
            act[p] = 0; vld[p] = 0; rq[p] = 0; k[p] = 0; len[p] = 0;
        end
    endtask

    task automatic drive();
        for (int p = 0; p < NP; p++) begin
            req_i[p]              = rq[p];
            valid_i[p]            = vld[p];
            flit_i[p*FW +: FW]    = mkflit(p);
        end
    endtask

    task automatic check_outputs();
        chk("valid_o", valid_o, m_valid);
        if (m_valid) chk("flit_o", flit_o, m_flit);
        for (int p = 0; p < NP; p++) begin
`ifdef OUT_ARB_STATS_EN
            chk("pkt_cnt", pkt_cnt_o[p*CW +: CW], m_cnt[p]);
`else
            chk("pkt_cnt", pkt_cnt_o[p*CW +: CW], 0);
`endif
        end
    endtask

    task automatic cycle();
        logic [1:0] t;
        drive();
        #1;
        win = -1;
        if (m_locked) win = m_lock;
        else begin
            for (int i = 0; i < NP; i++) begin
                int p;
                p = (m_ptr + i) % NP;
                if (win < 0 && rq[p] && vld[p] && (ftype(p) == 2'b00 || ftype(p) == 2'b11)) win = p;
            end
        end
        exp_ready = '0;
        if (win >= 0 && (!m_valid || ready_i)) exp_ready[win] = 1'b1;
        chk("ready_o", ready_o, exp_ready);
        seen_ready = ready_o;
        if (exp_ready != 0 && vld[win]) begin
            t       = ftype(win);
            m_flit  = mkflit(win);
            m_valid = 1;
            if (m_locked) begin
                if (t == 2'b10) begin m_locked = 0; m_ptr = (m_lock + 1) % NP; end
            end else if (t == 2'b00) begin
                m_locked = 1; m_lock = win;
            end else begin
                m_ptr = (win + 1) % NP;
            end
            if (t[1] && m_cnt[win] < 65535) m_cnt[win]++;
            k[win]++;
            if (k[win] == len[win]) begin act[win] = 0; vld[win] = 0; rq[win] = 0; end
        end else if (ready_i) begin
            m_valid = 0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    // Reset with the upstream still presenting its flits; both sides restart together.
    task automatic do_reset();
        drive();
        arst = 1'b1;
        #1;
        chk("rst_ready_o", ready_o, 0);
        @(posedge clk);
        #1;
        clear_upstream();
        m_locked = 0; m_lock = 0; m_ptr = 0; m_valid = 0; m_flit = '0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        chk("rst_valid_o", valid_o, 0);
        chk("rst_flit_o", flit_o, 0);
        chk("rst_pkt_cnt", pkt_cnt_o, 0);
        arst = 1'b0;
    endtask

    initial begin
        int exp_t[4];
        logic [FW-1:0] held;
        arst = 1'b1;
        ready_i = 1'b1;
        for (int p = 0; p < NP; p++) seq[p] = 0;
        clear_upstream();
        drive();
        @(posedge clk);
        #1;
        do_reset();

        // idle after reset
        repeat (10) begin
            cycle();
            chk("idle_valid", valid_o, 0);
            chk("idle_ready", seen_ready, 0);
        end

        // port 2 four-flit packet streams through with one cycle latency
        exp_t = '{0, 1, 1, 2};
        start(2, 4);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("p2_ready", seen_ready, 5'b00100);
            chk("p2_valid", valid_o, 1);
            chk("p2_type", flit_o[FW-1 -: 2], exp_t[i]);
        end
        cycle();
        chk("p2_drain", valid_o, 0);

        // ports 0 and 3 single-flit packets alternate
        do_reset();
        ready_i = 1'b1;
        begin
            int gseq[4];
            gseq = '{1, 8, 1, 8};
            for (int i = 0; i < 4; i++) begin
                if (!act[0]) start(0, 1);
                if (!act[3]) start(3, 1);
                cycle();
                chk("alt_grant", seen_ready, gseq[i]);
            end
        end

        // port 1 packet holds the output, port 4 head waits
        do_reset();
        start(1, 3);
        start(4, 2);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("lock_p1", seen_ready, 5'b00010);
        end
        cycle();
        chk("p4_next", seen_ready, 5'b10000);
        cycle();

        // downstream stall mid-packet
        do_reset();
        start(2, 4);
        cycle();
        cycle();
        ready_i = 1'b0;
        held = flit_o;
        repeat (5) begin
            cycle();
            chk("stall_ready", seen_ready, 0);
            chk("stall_flit", flit_o, held);
            chk("stall_valid", valid_o, 1);
        end
        ready_i = 1'b1;
        cycle();
        chk("resume_body", flit_o[FW-1 -: 2], 2'b01);
        cycle();
        chk("resume_tail", flit_o[FW-1 -: 2], 2'b10);
        cycle();
        chk("resume_drain", valid_o, 0);

        // reset in the middle of a packet clears lock and pointer
        do_reset();
        start(0, 1);
        cycle();
        start(3, 3);
        cycle();
        cycle();
        do_reset();
        start(0, 2);
        start(3, 2);
        cycle();
        chk("post_rst_win", seen_ready, 5'b00001);
        cycle();
        cycle();

        // three packets from port 2
        do_reset();
        for (int j = 0; j < 3; j++) begin
            start(2, 2);
            cycle();
            cycle();
        end
        cycle();
        chk("stats_p2", pkt_cnt_o[2*CW +: CW], EXP_P2);
        chk("stats_p0", pkt_cnt_o[0 +: CW], 0);

        // randomized traffic with occasional resets
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (c % 700 == 699) do_reset();
            for (int p = 0; p < NP; p++) begin
                if (!act[p] && ($urandom % 3 == 0)) start(p, 1 + int'($urandom % 4));
                if (act[p] != 0) begin
                    vld[p] = ($urandom % 4) != 0;
                    rq[p]  = ($urandom % 6) != 0;
                end
            end
            ready_i = ($urandom % 4) != 0;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
